// File: rtl/iobuf_halfduplex_ctrl.sv
// Half-duplex sequencer for one bank of tri-state IO buffers: round-robin grant between a
// write and a read requester, registered buffer enable, and bus-turnaround gaps.
module iobuf_halfduplex_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DRV_CYCLES = 2,
    parameter int RD_LAT     = 2,
    parameter int TA_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_req,
    output logic             rd_ack,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] iob_i,
    output logic             iob_t,
    input  logic [WIDTH-1:0] iob_o,
    output logic             busy
);

    localparam int MAX_DR  = (DRV_CYCLES > RD_LAT) ? DRV_CYCLES : RD_LAT;
    localparam int MAX_CYC = (MAX_DR > TA_CYCLES) ? MAX_DR : TA_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] DRV_LOAD = CNT_W'(DRV_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] TA_LOAD  = CNT_W'((TA_CYCLES > 0) ? TA_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_GAP
    } state_t;

    typedef enum logic {
        PRI_WRITE,
        PRI_READ
    } pri_t;

    // With no turnaround configured, a finished transfer returns straight to IDLE.
    localparam state_t AFTER_XFER = (TA_CYCLES > 0) ? ST_GAP : ST_IDLE;

    state_t           state, state_next;
    pri_t             pri, pri_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             wr_grant;
    logic             rd_grant;
    logic             rd_sample;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pri_next   = pri;
        wr_grant   = 1'b0;
        rd_grant   = 1'b0;
        rd_sample  = 1'b0;
        case (state)
            ST_IDLE: begin
                wr_grant = wr_valid & (~rd_req | (pri == PRI_WRITE));
                rd_grant = rd_req & (~wr_valid | (pri == PRI_READ));
                if (wr_grant) begin
                    state_next = ST_DRIVE;
                    cnt_next   = DRV_LOAD;
                    pri_next   = PRI_READ;
                end else if (rd_grant) begin
                    state_next = ST_WAIT;
                    cnt_next   = RD_LOAD;
                    pri_next   = PRI_WRITE;
                end
            end
            ST_DRIVE: begin
                if (cnt == '0) begin
                    state_next = AFTER_XFER;
                    cnt_next   = TA_LOAD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            ST_WAIT: begin
                // The pad is sampled on the edge that ends the last wait cycle.
                if (cnt == '0) begin
                    rd_sample  = 1'b1;
                    state_next = AFTER_XFER;
                    cnt_next   = TA_LOAD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // iob_t is registered from the next state so the pad enable never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            pri      <= PRI_WRITE;
            iob_t    <= 1'b1;
            iob_i    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            pri      <= pri_next;
            iob_t    <= (state_next != ST_DRIVE);
            rd_valid <= rd_sample;
            if (wr_grant) begin
                iob_i <= wr_data;
            end
            if (rd_sample) begin
                rd_data <= iob_o;
            end
        end
    end

    assign wr_ready = wr_grant;
    assign rd_ack   = rd_grant;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_iobuf_halfduplex_ctrl.sv
// Bench for iobuf_halfduplex_ctrl: directed vector table, multi-cycle corner sequences and
// randomized requesters checked against a transaction-level reference model.
module tb_iobuf_halfduplex_ctrl;

    localparam int DRV = 2;
    localparam int RDL = 2;
    localparam int TA  = 1;
    localparam int NRAND = 600;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       wr_valid, rd_req;
    logic [7:0] wr_data, iob_o;
    logic       wr_ready, rd_ack, rd_valid, iob_t, busy;
    logic [7:0] rd_data, iob_i;

    logic       f_wr_valid, f_rd_req;
    logic [7:0] f_wr_data, f_iob_o;
    logic       f_wr_ready, f_rd_ack, f_rd_valid, f_iob_t, f_busy;
    logic [7:0] f_rd_data, f_iob_i;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    iobuf_halfduplex_ctrl #(.WIDTH(8), .DRV_CYCLES(DRV), .RD_LAT(RDL), .TA_CYCLES(TA)) u_dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .iob_i(iob_i), .iob_t(iob_t), .iob_o(iob_o), .busy(busy)
    );

    iobuf_halfduplex_ctrl #(.WIDTH(8), .DRV_CYCLES(1), .RD_LAT(2), .TA_CYCLES(0)) u_fast (
        .clk(clk), .rst(rst),
        .wr_valid(f_wr_valid), .wr_data(f_wr_data), .wr_ready(f_wr_ready),
        .rd_req(f_rd_req), .rd_ack(f_rd_ack), .rd_valid(f_rd_valid), .rd_data(f_rd_data),
        .iob_i(f_iob_i), .iob_t(f_iob_t), .iob_o(f_iob_o), .busy(f_busy)
    );

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic [7:0] pad;
        logic       e_wr_ready;
        logic       e_rd_ack;
        logic       e_t;
        logic [7:0] e_iob_i;
        logic       e_rv;
        logic [7:0] e_rd_data;
        logic       e_busy;
    } vec_t;

    vec_t vecs[10];

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic applyStimulus(input vec_t v);
        wr_valid = v.wv;
        wr_data  = v.wd;
        rd_req   = v.rr;
        iob_o    = v.pad;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        wr_valid = 1'b0; rd_req = 1'b0; wr_data = '0; iob_o = '0;
        f_wr_valid = 1'b0; f_rd_req = 1'b0; f_wr_data = '0; f_iob_o = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        nextCycle();
    endtask

    initial begin
        logic       pend_w, pend_r, pri_read;
        logic [7:0] gw_data, m_iob_i, m_rd_data;
        logic [7:0] pad_hist[0:1023];
        int         next_free, gw, gr;
        logic       idle, ewr, erd;

        // write 0xA5 at c0, then a read of pad value 0x3C five cycles later
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 8'h3C, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h3C, 1'b0};

        doReset();
        checkBit("reset_iob_t", iob_t, 1'b1);
        checkOutput("reset_iob_i", iob_i, 8'h00);
        checkOutput("reset_rd_data", rd_data, 8'h00);
        checkBit("reset_rd_valid", rd_valid, 1'b0);
        checkBit("reset_busy", busy, 1'b0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkBit($sformatf("vec%0d_wr_ready", i), wr_ready, vecs[i].e_wr_ready);
            checkBit($sformatf("vec%0d_rd_ack", i), rd_ack, vecs[i].e_rd_ack);
            checkBit($sformatf("vec%0d_iob_t", i), iob_t, vecs[i].e_t);
            checkOutput($sformatf("vec%0d_iob_i", i), iob_i, vecs[i].e_iob_i);
            checkBit($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].e_rv);
            checkOutput($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].e_rd_data);
            checkBit($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            nextCycle();
        end

        // both requesters held from reset: writes at c0,c8 and reads at c4,c12
        doReset();
        wr_valid = 1'b1; rd_req = 1'b1; wr_data = 8'h77;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checkBit($sformatf("alt_c%0d_wr_ready", c), wr_ready, (c == 0) || (c == 8));
            checkBit($sformatf("alt_c%0d_rd_ack", c), rd_ack, (c == 4) || (c == 12));
            nextCycle();
        end
        wr_valid = 1'b0; rd_req = 1'b0;
        repeat (6) nextCycle();

        // reset in the middle of a drive phase
        doReset();
        wr_valid = 1'b1; wr_data = 8'h5A;
        @(negedge clk);
        checkBit("rstmid_grant", wr_ready, 1'b1);
        nextCycle();
        wr_valid = 1'b0;
        checkBit("rstmid_driving", iob_t, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkBit("rstmid_iob_t", iob_t, 1'b1);
        checkBit("rstmid_busy", busy, 1'b0);
        checkBit("rstmid_rd_valid", rd_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        nextCycle();
        wr_valid = 1'b1; rd_req = 1'b1;
        @(negedge clk);
        checkBit("rstmid_pri_wr", wr_ready, 1'b1);
        checkBit("rstmid_pri_rd", rd_ack, 1'b0);
        nextCycle();
        wr_valid = 1'b0; rd_req = 1'b0;
        repeat (8) nextCycle();

        // no turnaround, one drive cycle: back-to-back writes 0x01, 0x02
        doReset();
        f_wr_valid = 1'b1; f_wr_data = 8'h01;
        @(negedge clk);
        checkBit("fast_c0_ready", f_wr_ready, 1'b1);
        checkBit("fast_c0_t", f_iob_t, 1'b1);
        nextCycle();
        f_wr_data = 8'h02;
        @(negedge clk);
        checkBit("fast_c1_ready", f_wr_ready, 1'b0);
        checkBit("fast_c1_t", f_iob_t, 1'b0);
        checkOutput("fast_c1_iob_i", f_iob_i, 8'h01);
        checkBit("fast_c1_busy", f_busy, 1'b1);
        nextCycle();
        @(negedge clk);
        checkBit("fast_c2_ready", f_wr_ready, 1'b1);
        checkBit("fast_c2_t", f_iob_t, 1'b1);
        nextCycle();
        f_wr_valid = 1'b0;
        @(negedge clk);
        checkBit("fast_c3_t", f_iob_t, 1'b0);
        checkOutput("fast_c3_iob_i", f_iob_i, 8'h02);
        nextCycle();
        @(negedge clk);
        checkBit("fast_c4_t", f_iob_t, 1'b1);
        checkBit("fast_c4_busy", f_busy, 1'b0);
        checkBit("fast_rd_ack", f_rd_ack, 1'b0);
        checkBit("fast_rd_valid", f_rd_valid, 1'b0);
        checkOutput("fast_rd_data", f_rd_data, 8'h00);
        nextCycle();

        // randomized requesters against a transaction-level model
        doReset();
        pend_w = 1'b0; pend_r = 1'b0; pri_read = 1'b0;
        next_free = 0; gw = -1000; gr = -1000;
        gw_data = '0; m_iob_i = '0; m_rd_data = '0;
        for (int cyc = 0; cyc < NRAND; cyc++) begin
            if (!pend_w && $urandom_range(0, 2) == 0) begin
                pend_w  = 1'b1;
                wr_data = 8'($urandom);
            end
            if (!pend_r && $urandom_range(0, 2) == 0) pend_r = 1'b1;
            wr_valid = pend_w;
            rd_req   = pend_r;
            iob_o    = 8'($urandom);
            pad_hist[cyc] = iob_o;
            @(negedge clk);
            idle = (cyc >= next_free);
            ewr  = idle && pend_w && (!pend_r || !pri_read);
            erd  = idle && pend_r && (!pend_w || pri_read);
            if (cyc == gw + 1) m_iob_i = gw_data;
            if (cyc == gr + RDL + 1) m_rd_data = pad_hist[gr + RDL];
            checkBit("rnd_wr_ready", wr_ready, ewr);
            checkBit("rnd_rd_ack", rd_ack, erd);
            checkBit("rnd_iob_t", iob_t, !(cyc >= gw + 1 && cyc <= gw + DRV));
            checkBit("rnd_busy", busy, !idle);
            checkBit("rnd_rd_valid", rd_valid, cyc == gr + RDL + 1);
            checkOutput("rnd_rd_data", rd_data, m_rd_data);
            checkOutput("rnd_iob_i", iob_i, m_iob_i);
            if (ewr) begin
                gw = cyc; gw_data = wr_data;
                next_free = cyc + 1 + DRV + TA;
                pri_read = 1'b1; pend_w = 1'b0;
            end else if (erd) begin
                gr = cyc;
                next_free = cyc + 1 + RDL + TA;
                pri_read = 1'b0; pend_r = 1'b0;
            end
            nextCycle();
        end
        wr_valid = 1'b0; rd_req = 1'b0;
        repeat (6) nextCycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
